// File: rtl/sha256_msg_sched_if.sv
// Handshake/bus bundle between the SHA-256 message scheduler and its neighbours.
// The abort signal exists only when MSG_SCHED_ABORT_EN is defined.
interface sha256_msg_sched_if;
  logic         start;
  logic [511:0] block_in;
  logic         out_ready;
`ifdef MSG_SCHED_ABORT_EN
  logic         abort;
`endif
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   w_index;
  logic         busy;
  logic         done;

  modport master (
`ifdef MSG_SCHED_ABORT_EN
    output abort,
`endif
    output start, block_in, out_ready,
    input  w_valid, w_out, w_index, busy, done
  );

  modport slave (
`ifdef MSG_SCHED_ABORT_EN
    input  abort,
`endif
    input  start, block_in, out_ready,
    output w_valid, w_out, w_index, busy, done
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: streams W[0..63] from a 16-word sliding window.
// Optional feature macro: MSG_SCHED_ABORT_EN (adds an abort input honoured in RUN).
//
// state | meaning
// IDLE  | waiting for start; outputs zero
// RUN   | presenting W[t]; window slides on each handshake
// DONE  | one-cycle done pulse after W[63] was accepted
module sha256_msg_sched (
  input  logic              clk,
  input  logic              rst,
  sha256_msg_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  t_q, t_d;
  logic        hs;
  logic        abort_run;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  assign hs    = (state_q == RUN) && bus.out_ready;

`ifdef MSG_SCHED_ABORT_EN
  assign abort_run = (state_q == RUN) && bus.abort;
`else
  assign abort_run = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN: begin
        if (abort_run)                  state_d = IDLE;
        else if (hs && t_q == 6'd63)    state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort takes priority over a coincident handshake, so the window freezes.
  always_comb begin
    t_d = t_q;
    for (int i = 0; i < 16; i++) win_d[i] = win_q[i];
    if (state_q == IDLE && bus.start) begin
      t_d = '0;
      for (int i = 0; i < 16; i++) win_d[i] = bus.block_in[511 - 32*i -: 32];
    end else if (hs && !abort_run) begin
      t_d = t_q + 6'd1;
      for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
      win_d[15] = w_new;
    end
  end

  always_comb begin
    bus.w_valid = (state_q == RUN);
    bus.w_out   = (state_q == RUN) ? win_q[0] : 32'd0;
    bus.w_index = (state_q == RUN) ? t_q : 6'd0;
    bus.busy    = (state_q != IDLE);
    bus.done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched; expected words come from a direct
// W[t] recurrence model queued at start and popped on each handshake.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  logic rst;

  sha256_msg_sched_if bus ();

  sha256_msg_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] exp_q [$];
  logic [31:0] obs_w [64];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ms0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ms1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic push_model(input logic [511:0] b);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge; returns at the negedge where W[0] should be valid.
  task automatic drive_start(input logic [511:0] b);
    bus.start    = 1'b1;
    bus.block_in = b;
    push_model(b);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.block_in = rand_block();
    check("start_latency_valid", 64'(bus.w_valid), 64'd1);
  endtask

  task automatic stream(input bit rand_ready, input bit start_t5, input bit start_done);
    int          hs = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [31:0] prev_w = '0;
    logic [5:0]  prev_i = '0;
    while (hs < 64 && cyc < 2000) begin
      check("valid", 64'(bus.w_valid), 64'd1);
      check("index", 64'(bus.w_index), 64'(hs));
      if (stalled) begin
        check("stall_w_out", 64'(bus.w_out), 64'(prev_w));
        check("stall_index", 64'(bus.w_index), 64'(prev_i));
      end
      if (exp_q.size() == 0) check("queue_empty", 64'd0, 64'd1);
      else check("w_out", 64'(bus.w_out), 64'(exp_q[0]));
      check("no_done", 64'(bus.done), 64'd0);
      obs_w[hs] = bus.w_out;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_t5 && hs == 5) begin
        bus.start    = 1'b1;
        bus.block_in = rand_block();
      end else begin
        bus.start = 1'b0;
      end
      stalled = !bus.out_ready;
      prev_w  = bus.w_out;
      prev_i  = bus.w_index;
      if (bus.out_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (hs < 64) check("stream_timeout", 64'(hs), 64'd64);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("done_busy", 64'(bus.busy), 64'd1);
    check("done_valid", 64'(bus.w_valid), 64'd0);
    if (start_done) begin
      bus.start    = 1'b1;
      bus.block_in = rand_block();
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("after_done", 64'(bus.done), 64'd0);
    check("after_busy", 64'(bus.busy), 64'd0);
    check("after_valid", 64'(bus.w_valid), 64'd0);
  endtask

  initial begin
    logic [511:0] abc;
    abc = {32'h61626380, 448'd0, 32'h00000018};
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.block_in  = '0;
    bus.out_ready = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
    bus.abort     = 1'b0;
`endif
    #1;
    check("rst_valid", 64'(bus.w_valid), 64'd0);
    check("rst_w_out", 64'(bus.w_out), 64'd0);
    check("rst_index", 64'(bus.w_index), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // "abc" block, ready held high
    drive_start(abc);
    stream(1'b0, 1'b0, 1'b0);
    check("abc_w0", 64'(obs_w[0]), 64'h61626380);
    check("abc_w15", 64'(obs_w[15]), 64'h00000018);
    check("abc_w16", 64'(obs_w[16]), 64'h61626380);
    check("abc_w17", 64'(obs_w[17]), 64'h000F0000);

    // back-to-back, same block under random backpressure
    drive_start(abc);
    stream(1'b1, 1'b0, 1'b0);

    // start pulses at t=5 and during DONE are ignored
    drive_start(rand_block());
    stream(1'b0, 1'b1, 1'b1);

    // reset mid-run at t=20
    drive_start(rand_block());
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_rst_index", 64'(bus.w_index), 64'd20);
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.w_valid), 64'd0);
    check("midrst_w_out", 64'(bus.w_out), 64'd0);
    check("midrst_index", 64'(bus.w_index), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 64'(bus.done), 64'd0);
    end
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    drive_start(rand_block());
    stream(1'b1, 1'b0, 1'b0);

`ifdef MSG_SCHED_ABORT_EN
    drive_start(rand_block());
    bus.out_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("pre_abort_index", 64'(bus.w_index), 64'd30);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_valid", 64'(bus.w_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check("abort_done2", 64'(bus.done), 64'd0);
    exp_q.delete();
    drive_start(rand_block());
    stream(1'b0, 1'b0, 1'b0);
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
